ppu_timing_gen: RTL and testbench

- Parametrised dot/line timing generator for the PPU; successor to the fixed-constant mode sequencer.
- Tracks dot-within-line and line (LY); decodes mode 0-3 and the VRAM/OAM lock flags.
- Adds LCD enable, LY==LYC compare, STAT interrupt sources with edge blocking, and VBLANK/frame pulses.
- Sits between the CPU clock-enable domain and the pixel fetcher, STAT/LY registers and interrupt controller.

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/ppu_timing_gen_stat_irq.sv | 40 ++++
 rtl/ppu_timing_gen.sv | 108 ++++++++++
 tb/tb_ppu_timing_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types and default timing for the PPU dot/line timing generator.
// Mode encoding matches the STAT register mode field.
package ppu_pkg;

    typedef enum logic [1:0] {
        HBLANK         = 2'd0,
        VBLANK         = 2'd1,
        OAM_SEARCH     = 2'd2,
        ACTIVE_PICTURE = 2'd3
    } ppu_mode_t;

    localparam int DEF_DOTS_PER_TICK = 2;
    localparam int DEF_DOTS_PER_LINE = 456;
    localparam int DEF_OAM_DOTS      = 80;
    localparam int DEF_XFER_DOTS     = 172;
    localparam int DEF_VISIBLE_LINES = 144;
    localparam int DEF_TOTAL_LINES   = 154;

    // Bit positions inside the STAT interrupt enable field.
    localparam int STAT_IE_MODE0 = 0;
    localparam int STAT_IE_MODE1 = 1;
    localparam int STAT_IE_MODE2 = 2;
    localparam int STAT_IE_LYC   = 3;

endpackage

// File: rtl/ppu_timing_gen_stat_irq.sv
// Combined STAT interrupt line with rising-edge pulse; a source that turns on
// while another already holds the line high is swallowed (STAT blocking).
module ppu_stat_irq
    import ppu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       lcd_en,
    input  ppu_mode_t  mode,
    input  logic       lyc_match,
    input  logic [3:0] stat_ie,
    output logic       stat_line,
    output logic       stat_irq
);

    logic stat_line_q;

    always_comb begin
        stat_line = lcd_en &
                    ((stat_ie[STAT_IE_MODE0] & (mode == HBLANK))     |
                     (stat_ie[STAT_IE_MODE1] & (mode == VBLANK))     |
                     (stat_ie[STAT_IE_MODE2] & (mode == OAM_SEARCH)) |
                     (stat_ie[STAT_IE_LYC]   & lyc_match));
    end

    // The previous level is forgotten while the LCD is off so a re-enable starts clean.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_line_q <= 1'b0;
            stat_irq    <= 1'b0;
        end else if (!lcd_en) begin
            stat_line_q <= 1'b0;
            stat_irq    <= 1'b0;
        end else begin
            stat_line_q <= stat_line;
            stat_irq    <= stat_line & ~stat_line_q;
        end
    end

endmodule

// File: rtl/ppu_timing_gen.sv
// Dot/line counters, mode decode, VRAM/OAM lock flags, LY==LYC compare and
// VBLANK/frame pulses for the PPU; STAT interrupt logic lives in ppu_stat_irq.
module ppu_timing_gen
    import ppu_pkg::*;
#(
    parameter int DOTS_PER_TICK = DEF_DOTS_PER_TICK,
    parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
    parameter int OAM_DOTS      = DEF_OAM_DOTS,
    parameter int XFER_DOTS     = DEF_XFER_DOTS,
    parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
    parameter int TOTAL_LINES   = DEF_TOTAL_LINES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic       lyc_match,
    output logic       vram_access,
    output logic       oam_access,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       frame_start
);

    localparam logic [8:0] DOT_STEP  = 9'(DOTS_PER_TICK);
    localparam logic [8:0] LINE_END  = 9'(DOTS_PER_LINE);
    localparam logic [8:0] OAM_END   = 9'(OAM_DOTS);
    localparam logic [8:0] XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] VBL_LINE  = 8'(VISIBLE_LINES);
    localparam logic [7:0] LAST_LINE = 8'(TOTAL_LINES);

    ppu_mode_t  mode_dec;
    logic [8:0] dot_inc;
    logic [7:0] ly_inc;
    logic       stat_line;

    assign dot_inc = dot + DOT_STEP;
    assign ly_inc  = ly + 8'd1;

    // Disabling the LCD parks the counters at line 0 dot 0 without any pulse;
    // the LYC compare is refreshed every clock so lyc writes land one clock later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dot         <= '0;
            ly          <= '0;
            lyc_match   <= 1'b0;
            vblank_irq  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vblank_irq  <= 1'b0;
            frame_start <= 1'b0;
            lyc_match   <= lcd_en & (ly == lyc);
            if (!lcd_en) begin
                dot <= '0;
                ly  <= '0;
            end else if (tick_en) begin
                if (dot_inc == LINE_END) begin
                    dot <= '0;
                    if (ly_inc == LAST_LINE) begin
                        ly          <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        ly         <= ly_inc;
                        vblank_irq <= (ly_inc == VBL_LINE);
                    end
                end else begin
                    dot <= dot_inc;
                end
            end
        end
    end

    always_comb begin
        mode_dec = HBLANK;
        if (lcd_en) begin
            if (ly >= VBL_LINE) begin
                mode_dec = VBLANK;
            end else if (dot < OAM_END) begin
                mode_dec = OAM_SEARCH;
            end else if (dot < XFER_END) begin
                mode_dec = ACTIVE_PICTURE;
            end else begin
                mode_dec = HBLANK;
            end
        end
    end

    assign mode        = mode_dec;
    assign vram_access = (mode_dec == ACTIVE_PICTURE);
    assign oam_access  = (mode_dec == OAM_SEARCH) || (mode_dec == ACTIVE_PICTURE);

    ppu_stat_irq u_stat_irq (
        .clock     (clock),
        .reset     (reset),
        .lcd_en    (lcd_en),
        .mode      (mode_dec),
        .lyc_match (lyc_match),
        .stat_ie   (stat_ie),
        .stat_line (stat_line),
        .stat_irq  (stat_irq)
    );

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Self-checking bench for ppu_timing_gen: a tick-count frame model checked every
// clock, plus directed checks at the mode, line, frame, LYC and LCD-enable boundaries.
module tb_ppu_timing_gen;

    localparam int DPL         = 456;
    localparam int VIS         = 144;
    localparam int TOTAL       = 154;
    localparam int FRAME_TICKS = DPL * TOTAL / 2;

    logic       clock;
    logic       reset;
    logic       tick_en;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       lyc_match;
    logic       vram_access;
    logic       oam_access;
    logic       vblank_irq;
    logic       stat_irq;
    logic       frame_start;

    int total;
    int bad;
    int stat_cnt [256];
    int vblank_cnt;
    int frame_cnt;

    int m_t;
    bit m_lyc_match;
    bit m_line_q;
    bit m_stat_irq;
    bit m_vblank;
    bit m_frame;

    ppu_timing_gen dut (
        .clock       (clock),
        .reset       (reset),
        .tick_en     (tick_en),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .stat_ie     (stat_ie),
        .mode        (mode),
        .ly          (ly),
        .dot         (dot),
        .lyc_match   (lyc_match),
        .vram_access (vram_access),
        .oam_access  (oam_access),
        .vblank_irq  (vblank_irq),
        .stat_irq    (stat_irq),
        .frame_start (frame_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int exp_dot(input int t);
        return (t * 2) % DPL;
    endfunction

    function automatic int exp_ly(input int t);
        return ((t * 2) / DPL) % TOTAL;
    endfunction

    function automatic int exp_mode(input int t, input bit en);
        if (!en) return 0;
        if (exp_ly(t) >= VIS) return 1;
        if (exp_dot(t) < 80) return 2;
        if (exp_dot(t) < 80 + 172) return 3;
        return 0;
    endfunction

    // Frame model: position is simply the number of ticks since line 0 dot 0.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_t         = 0;
            m_lyc_match = 1'b0;
            m_line_q    = 1'b0;
            m_stat_irq  = 1'b0;
            m_vblank    = 1'b0;
            m_frame     = 1'b0;
        end else begin
            automatic int  cm = exp_mode(m_t, lcd_en);
            automatic bit  line = lcd_en && ((stat_ie[0] && cm == 0) || (stat_ie[1] && cm == 1) ||
                                             (stat_ie[2] && cm == 2) || (stat_ie[3] && m_lyc_match));
            m_stat_irq  = line && !m_line_q;
            m_line_q    = line;
            m_lyc_match = lcd_en && (exp_ly(m_t) == int'(lyc));
            m_vblank    = 1'b0;
            m_frame     = 1'b0;
            if (!lcd_en) begin
                m_t = 0;
            end else if (tick_en) begin
                m_t = m_t + 1;
                if (m_t == FRAME_TICKS) begin
                    m_t     = 0;
                    m_frame = 1'b1;
                end else if (m_t * 2 == VIS * DPL) begin
                    m_vblank = 1'b1;
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle compare against the model, plus pulse bookkeeping for the directed checks.
    always begin
        @(posedge clock);
        #1;
        begin
            automatic int em = exp_mode(m_t, lcd_en);
            automatic logic [31:0] got = {dot, ly, mode, lyc_match, vram_access, oam_access,
                                          vblank_irq, stat_irq, frame_start};
            automatic logic [31:0] want = {9'(exp_dot(m_t)), 8'(exp_ly(m_t)), 2'(em), m_lyc_match,
                                           (em == 3), (em >= 2), m_vblank, m_stat_irq, m_frame};
            check_output("cycle_model", int'(got), int'(want));
        end
        if (stat_irq)    stat_cnt[ly] = stat_cnt[ly] + 1;
        if (vblank_irq)  vblank_cnt   = vblank_cnt + 1;
        if (frame_start) frame_cnt    = frame_cnt + 1;
    end

    task automatic apply_stimulus(input int n);
        @(negedge clock);
        tick_en = 1'b1;
        repeat (n) @(negedge clock);
        tick_en = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        vblank_cnt = 0;
        frame_cnt  = 0;
        for (int i = 0; i < 256; i++) stat_cnt[i] = 0;
        reset   = 1'b0;
        lcd_en  = 1'b1;
        tick_en = 1'b0;
        lyc     = 8'd5;
        stat_ie = 4'b1000;
        #3;
        check_output("reset_dot", int'(dot), 0);
        check_output("reset_ly", int'(ly), 0);
        check_output("reset_mode", int'(mode), 2);
        check_output("reset_pulses", int'({vblank_irq, stat_irq, frame_start, lyc_match}), 0);
        @(negedge clock);
        reset = 1'b1;

        apply_stimulus(40);
        check_output("t40_dot", int'(dot), 80);
        check_output("t40_mode", int'(mode), 3);
        check_output("t40_vram", int'(vram_access), 1);
        apply_stimulus(86);
        check_output("t126_dot", int'(dot), 252);
        check_output("t126_mode", int'(mode), 0);
        check_output("t126_oam", int'(oam_access), 0);
        apply_stimulus(102);
        check_output("eol_dot", int'(dot), 0);
        check_output("eol_ly", int'(ly), 1);
        check_output("eol_mode", int'(mode), 2);

        apply_stimulus(4 * 228);
        repeat (3) @(negedge clock);
        check_output("lyc5_ly", int'(ly), 5);
        check_output("lyc5_match", int'(lyc_match), 1);
        check_output("lyc5_irq_cnt", stat_cnt[5], 1);
        apply_stimulus(228);
        repeat (2) @(negedge clock);
        check_output("ly6_match", int'(lyc_match), 0);
        check_output("ly6_irq_cnt", stat_cnt[6], 0);

        stat_ie = 4'b1001;
        lyc     = 8'd143;
        apply_stimulus(137 * 228);
        repeat (3) @(negedge clock);
        check_output("ly143_irq_cnt", stat_cnt[143], 1);
        apply_stimulus(228);
        check_output("ly143_blocked", stat_cnt[143], 1);
        check_output("vbl_ly", int'(ly), 144);
        check_output("vbl_mode", int'(mode), 1);
        check_output("vbl_irq_now", int'(vblank_irq), 1);
        @(negedge clock);
        check_output("vbl_irq_width", int'(vblank_irq), 0);
        check_output("vbl_irq_cnt", vblank_cnt, 1);

        apply_stimulus(10 * 228 - 1);
        check_output("pre_wrap_ly", int'(ly), 153);
        check_output("pre_wrap_dot", int'(dot), 454);
        check_output("pre_wrap_frame_cnt", frame_cnt, 0);
        apply_stimulus(1);
        check_output("wrap_ly", int'(ly), 0);
        check_output("wrap_dot", int'(dot), 0);
        check_output("wrap_mode", int'(mode), 2);
        check_output("wrap_frame_start", int'(frame_start), 1);
        @(negedge clock);
        check_output("wrap_frame_cnt", frame_cnt, 1);

        apply_stimulus(77 * 228);
        check_output("pre_off_ly", int'(ly), 77);
        lcd_en = 1'b0;
        @(negedge clock);
        check_output("off_ly", int'(ly), 0);
        check_output("off_dot", int'(dot), 0);
        check_output("off_mode", int'(mode), 0);
        check_output("off_flags", int'({vram_access, oam_access, lyc_match}), 0);
        check_output("off_pulses", int'({vblank_irq, stat_irq, frame_start}), 0);
        repeat (3) @(negedge clock);
        lcd_en = 1'b1;
        @(negedge clock);
        check_output("on_mode", int'(mode), 2);
        repeat (3) @(negedge clock);
        check_output("on_frame_cnt", frame_cnt, 1);
        check_output("on_vbl_cnt", vblank_cnt, 1);

        apply_stimulus(30 * 228 + 150);
        check_output("mid_ly", int'(ly), 30);
        check_output("mid_dot", int'(dot), 300);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_dot", int'(dot), 0);
        check_output("async_ly", int'(ly), 0);
        check_output("async_pulses", int'({vblank_irq, stat_irq, frame_start, lyc_match}), 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
